// File: rtl/cp0_unit_if.sv
// Control-FSM <-> CP0 bus: register access, interrupt lines and EXL handshake.
// The master drives the requests and lines; the slave (CP0) returns IntReq/EPC/DOut.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic [31:0] PC;
  logic [5:0]  HWInt;
  logic        Wen;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, PC, HWInt, Wen, EXLSet, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, PC, HWInt, Wen, EXLSet, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt request generation and the EXL
// entry/eret handshake with the multi-cycle control FSM.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE  = 32'h4D49_5053,
  parameter logic [31:0] EPC_RESET   = 32'h0000_3000,
  parameter int          SYNC_STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  cp0_unit_if.slave bus
);

  logic [5:0]  im;
  logic        ie;
  logic        exl;
  logic [31:0] epc;
  logic [5:0]  sync0;
  logic [5:0]  sync1;
  logic [5:0]  ip;

  // Second stage only feeds IP when a two-flop synchroniser is selected.
  assign ip = (SYNC_STAGES == 2) ? sync1 : sync0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= bus.HWInt;
      sync1 <= sync0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
      epc <= EPC_RESET;
    end else if (bus.EXLSet) begin
      // Capture only on the entry edge; software writes are blocked while servicing.
      if (!exl) begin
        exl <= 1'b1;
        epc <= bus.PC;
      end
    end else begin
      if (bus.EXLClr)
        exl <= 1'b0;
      if (bus.Wen) begin
        case (bus.A2)
          5'd12: begin
            im <= bus.DIn[15:10];
            ie <= bus.DIn[0];
          end
          5'd14: epc <= bus.DIn;
          default: ;
        endcase
      end
    end
  end

  assign bus.IntReq = (|(ip & im)) & ie & ~exl;
  assign bus.EPC    = epc;

  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      5'd12:   bus.DOut = {16'h0000, im, 8'h00, exl, ie};
      5'd13:   bus.DOut = {16'h0000, ip, 10'h000};
      5'd14:   bus.DOut = epc;
      5'd15:   bus.DOut = PRID_VALUE;
      default: bus.DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a register-level model.
`timescale 1ns/100ps
module tb_cp0_unit;
  localparam int          SS    = 1;
  localparam logic [31:0] PRID  = 32'h4D49_5053;
  localparam logic [31:0] EPCR  = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  cp0_unit_if bus ();

  cp0_unit #(.PRID_VALUE(PRID), .EPC_RESET(EPCR), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: register contents plus an SS-deep delay line for IP.
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_valid = 1'b0;
  logic [31:0] m_epc;
  logic [5:0]  hw_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_epc = EPCR; m_ip = '0;
      hw_q.delete();
      for (int i = 0; i < SS; i++) hw_q.push_back(6'h00);
      m_valid = 1'b1;
    end else if (m_valid) begin
      hw_q.push_back(bus.HWInt);
      void'(hw_q.pop_front());
      m_ip = hw_q[0];
      if (bus.EXLSet) begin
        if (!m_exl) begin
          m_exl = 1'b1;
          m_epc = bus.PC;
        end
      end else begin
        if (bus.EXLClr) m_exl = 1'b0;
        if (bus.Wen && bus.A2 == 5'd12) begin
          m_im = bus.DIn[15:10];
          m_ie = bus.DIn[0];
        end
        if (bus.Wen && bus.A2 == 5'd14) m_epc = bus.DIn;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 5'd12) r = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
    if (a == 5'd13) r = 32'(m_ip) << 10;
    if (a == 5'd14) r = m_epc;
    if (a == 5'd15) r = PRID;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_intreq", 32'(bus.IntReq),
          32'((|(m_ip & m_im)) && m_ie && !m_exl));
      chk("model_epc", bus.EPC, m_epc);
      chk("model_dout", bus.DOut, model_read(bus.A1));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    bus.A1 = a;
    #1;
    chk(nm, bus.DOut, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.A1 = 5'd12; bus.A2 = 5'd0; bus.DIn = '0; bus.PC = '0;
    bus.HWInt = 6'h3F; bus.Wen = 1'b0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
    stepn(2);
    chk("rst_intreq", 32'(bus.IntReq), 32'h0);
    chk("rst_epc", bus.EPC, 32'h0000_3000);
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd15, 32'h4D49_5053, "rst_prid");

    rst = 1'b0; bus.HWInt = 6'h00;
    bus.Wen = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC03;
    step();
    rd(5'd12, 32'h0000_FC01, "mtc0_sr");
    bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    step();
    bus.Wen = 1'b0;
    rd(5'd13, 32'h0, "cause_ro");

    bus.HWInt = 6'b000100;
    stepn(SS);
    chk("int_pending", 32'(bus.IntReq), 32'h1);
    rd(5'd13, 32'h0000_1000, "cause_ip2");

    bus.Wen = 1'b1; bus.EXLSet = 1'b1; bus.PC = 32'h0000_3040;
    step();
    bus.Wen = 1'b0;
    chk("entry_epc", bus.EPC, 32'h0000_3040);
    chk("entry_intreq", 32'(bus.IntReq), 32'h0);
    rd(5'd12, 32'h0000_FC03, "entry_sr");
    for (int i = 0; i < 5; i++) begin
      bus.PC = $urandom;
      step();
    end
    chk("hold_epc", bus.EPC, 32'h0000_3040);

    bus.EXLSet = 1'b0; bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;
    chk("eret_reassert", 32'(bus.IntReq), 32'h1);
    rd(5'd12, 32'h0000_FC01, "eret_sr");
    bus.HWInt = 6'h00;
    stepn(SS);
    chk("line_drop", 32'(bus.IntReq), 32'h0);

    bus.Wen = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401; bus.HWInt = 6'b000010;
    step();
    bus.Wen = 1'b0;
    stepn(SS);
    chk("mask_im", 32'(bus.IntReq), 32'h0);
    rd(5'd13, 32'h0000_0800, "mask_cause1");
    bus.Wen = 1'b1; bus.DIn = 32'h0000_FC00; bus.HWInt = 6'b000001;
    step();
    bus.Wen = 1'b0;
    stepn(SS);
    chk("mask_ie", 32'(bus.IntReq), 32'h0);
    rd(5'd13, 32'h0000_0400, "mask_cause2");

    bus.EXLSet = 1'b1; bus.EXLClr = 1'b1; bus.PC = 32'h1234_5678;
    step();
    chk("conflict_epc", bus.EPC, 32'h1234_5678);
    rd(5'd12, 32'h0000_FC02, "conflict_sr");
    bus.Wen = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hAAAA_AAAA;
    step();
    chk("wen_suppressed", bus.EPC, 32'h1234_5678);
    bus.Wen = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_epc", bus.EPC, 32'h0000_3000);
    rd(5'd12, 32'h0, "midrst_sr");

    bus.Wen = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hAAAA_AAAA; bus.PC = 32'h0000_5555;
    bus.EXLSet = 1'b1; bus.EXLClr = 1'b0;
    step();
    chk("capture_priority", bus.EPC, 32'h0000_5555);
    bus.EXLSet = 1'b0; bus.EXLClr = 1'b1;
    step();
    chk("mtc0_epc", bus.EPC, 32'hAAAA_AAAA);
    bus.Wen = 1'b0; bus.EXLClr = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      bus.Wen    = ($urandom_range(0, 99) < 30);
      bus.EXLSet = ($urandom_range(0, 99) < 20);
      bus.EXLClr = ($urandom_range(0, 99) < 30);
      bus.A2     = ($urandom_range(0, 1) == 1) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      bus.A1     = ($urandom_range(0, 1) == 1) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      bus.DIn    = $urandom;
      bus.PC     = $urandom;
      bus.HWInt  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
